// File: rtl/noc_pkg.sv
// Shared mesh flit constants and receive-FSM state encoding.
// Pure definitions: no latency, no flow control.
package noc_pkg;

   localparam int FLIT_W         = 9;
   localparam int FLIT_VALID_BIT = 8;
   localparam logic [FLIT_W-1:0] NO_DATA = 9'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/rx_fifo.sv
// Synchronous payload FIFO; push visible on dout/count the cycle after, pop advances head next cycle.
// No backpressure: push into a full FIFO is dropped unless a pop happens in the same cycle.
module rx_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          push,
   input  logic                          pop,
   input  logic [DATA_W-1:0]             din,
   output logic [DATA_W-1:0]             dout,
   output logic                          full,
   output logic                          empty,
   output logic [$clog2(FIFO_DEPTH):0]   count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q;
   logic [AW-1:0]     rd_ptr_q;
   logic [AW:0]       count_q;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == DEPTH_C);
   assign count   = count_q;
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign dout    = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/pu_receive_unit.sv
// Mesh burst receiver: header, payload into FIFO, rx_done one cycle after last flit; no backpressure.
// RX_CHECKSUM_EN adds a trailing XOR checksum flit checked in the CHECK state.
module pu_receive_unit
   import noc_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [DATA_W:0]             data_from_router,
   input  logic                        rd_en,
   output logic [DATA_W-1:0]           rd_data,
   output logic                        rd_valid,
   output logic                        rx_busy,
   output logic                        rx_done,
   output logic [DATA_W-1:0]           rx_len,
   output logic                        rx_error,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

   rx_state_e         state_q, state_d;
   logic [DATA_W-1:0] len_q, len_d;
   logic [DATA_W-1:0] remaining_q, remaining_d;
   logic [DATA_W-1:0] rx_len_q, rx_len_d;
   logic [TW-1:0]     idle_q, idle_d;
   logic              rx_error_q, rx_error_d;
   logic              overflow_q;
`ifdef RX_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
`endif

   logic              flit_vld;
   logic [DATA_W-1:0] flit_dat;
   logic              push;
   logic              fifo_full;
   logic              fifo_empty;
   logic              timeout;

   assign flit_vld = data_from_router[DATA_W];
   assign flit_dat = data_from_router[DATA_W-1:0];
   assign push     = (state_q == RECV) && flit_vld;
   assign timeout  = !flit_vld && (idle_q == IDLE_LAST);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      remaining_d = remaining_q;
      rx_len_d    = rx_len_q;
      idle_d      = idle_q;
      rx_error_d  = 1'b0;
`ifdef RX_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         IDLE: begin
            idle_d = '0;
            if (flit_vld) begin
               len_d       = flit_dat;
               remaining_d = flit_dat;
`ifdef RX_CHECKSUM_EN
               csum_d      = '0;
`endif
               if (flit_dat == '0) begin
`ifdef RX_CHECKSUM_EN
                  state_d  = CHECK;
`else
                  state_d  = DONE;
                  rx_len_d = flit_dat;
`endif
               end else begin
                  state_d = RECV;
               end
            end
         end
         RECV: begin
            if (flit_vld) begin
               idle_d      = '0;
               remaining_d = remaining_q - DATA_W'(1);
`ifdef RX_CHECKSUM_EN
               csum_d      = csum_q ^ flit_dat;
`endif
               if (remaining_q == DATA_W'(1)) begin
`ifdef RX_CHECKSUM_EN
                  state_d  = CHECK;
`else
                  state_d  = DONE;
                  rx_len_d = len_q;
`endif
               end
            end else if (timeout) begin
               rx_error_d = 1'b1;
               state_d    = IDLE;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
`ifdef RX_CHECKSUM_EN
         CHECK: begin
            if (flit_vld) begin
               state_d    = DONE;
               rx_len_d   = len_q;
               rx_error_d = (flit_dat != csum_q);
            end else if (timeout) begin
               rx_error_d = 1'b1;
               state_d    = IDLE;
            end else begin
               idle_d = idle_q + TW'(1);
            end
         end
`endif
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         remaining_q <= '0;
         rx_len_q    <= '0;
         idle_q      <= '0;
         rx_error_q  <= 1'b0;
         overflow_q  <= 1'b0;
`ifdef RX_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         remaining_q <= remaining_d;
         rx_len_q    <= rx_len_d;
         idle_q      <= idle_d;
         rx_error_q  <= rx_error_d;
         // Dropped flit still counts toward remaining so framing survives.
         if (push && fifo_full && !rd_en) overflow_q <= 1'b1;
`ifdef RX_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   rx_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_rx_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push),
      .pop   (rd_en),
      .din   (flit_dat),
      .dout  (rd_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rd_valid = !fifo_empty;
   assign rx_busy  = (state_q != IDLE);
   assign rx_done  = (state_q == DONE);
   assign rx_len   = rx_len_q;
   assign rx_error = rx_error_q;
   assign overflow = overflow_q;

endmodule
